// File: rtl/uart_stim_pkg.sv
// Shared definitions for the UART stimulus transmitter: FSM encoding and 8N1 frame constants.
package uart_stim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    localparam int   DATA_BITS = 8;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;

endpackage

// File: rtl/uart_stim_tx_if.sv
// Byte-push and status bundle between a stimulus source (master) and the transmitter (slave).
interface uart_stim_tx_if #(
    parameter int FIFO_DEPTH = 8
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full;
    logic [CW-1:0] count;
    logic          overflow;
    logic          busy;
    logic          tx;

    modport master (output wr_en, wr_data, input full, count, overflow, busy, tx);
    modport slave  (input wr_en, wr_data, output full, count, overflow, busy, tx);
endinterface

// File: rtl/uart_stim_fifo.sv
// Synchronous byte FIFO with registered count/full; a push while full is dropped and latches overflow.
module uart_stim_fifo #(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic [7:0]    pop_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          overflow
);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic [CW-1:0] cnt_next;

    // full is the registered flag, so a same-cycle pop never rescues a push
    assign push_ok  = push && !full;
    assign pop_data = mem[rd_ptr];

    always_comb begin
        cnt_next = count;
        if (push_ok && !pop) begin
            cnt_next = count + 1'b1;
        end else if (!push_ok && pop) begin
            cnt_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            count <= cnt_next;
            full  <= (cnt_next == FULL_CNT);
            if (push && full) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !rst) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_stim_tx.sv
// 8N1 UART transmitter fed from a byte FIFO; frames are sent back-to-back while data is queued.
module uart_stim_tx
    import uart_stim_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input logic          HCLK,
    input logic          HRESET,
    uart_stim_tx_if.slave bus
);
    localparam int            CW        = $clog2(FIFO_DEPTH) + 1;
    localparam int            BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

    tx_state_t     state;
    tx_state_t     state_next;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          tx_q;
    logic          tx_next;
    logic          pop;
    logic          bit_end;
    logic [7:0]    fifo_data;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_ovf;
    logic          fifo_nonempty;

    uart_stim_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk       (HCLK),
        .rst       (HRESET),
        .push      (bus.wr_en),
        .push_data (bus.wr_data),
        .pop       (pop),
        .pop_data  (fifo_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .overflow  (fifo_ovf)
    );

    assign bit_end       = (baud_cnt == BAUD_LAST);
    assign fifo_nonempty = (fifo_count != '0);

    always_ff @(posedge HCLK) begin
        if (HRESET) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (fifo_nonempty) state_next = ST_START;
            ST_START: if (bit_end) state_next = ST_DATA;
            ST_DATA:  if (bit_end && (bit_cnt == BIT_LAST)) state_next = ST_STOP;
            ST_STOP:  if (bit_end) state_next = fifo_nonempty ? ST_START : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // tx is registered from the state, so the line trails the FSM by one cycle uniformly
    always_comb begin
        pop     = 1'b0;
        tx_next = IDLE_LVL;
        case (state)
            ST_IDLE:  pop = fifo_nonempty;
            ST_START: tx_next = START_LVL;
            ST_DATA:  tx_next = shreg[0];
            ST_STOP: begin
                tx_next = STOP_LVL;
                pop     = bit_end && fifo_nonempty;
            end
            default:  tx_next = IDLE_LVL;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx_q     <= IDLE_LVL;
        end else begin
            tx_q <= tx_next;
            if (state == ST_IDLE || bit_end) baud_cnt <= '0;
            else                             baud_cnt <= baud_cnt + 1'b1;
            if (state != ST_DATA) bit_cnt <= '0;
            else if (bit_end)     bit_cnt <= bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (pop)                              shreg <= fifo_data;
        else if (state == ST_DATA && bit_end) shreg <= {1'b0, shreg[7:1]};
    end

    assign bus.tx       = tx_q;
    assign bus.full     = fifo_full;
    assign bus.count    = fifo_count;
    assign bus.overflow = fifo_ovf;
    assign bus.busy     = (state != ST_IDLE) || fifo_nonempty;

endmodule

// File: tb/tb_uart_stim_tx.sv
// Scoreboard bench: bytes queued on push, serial frames decoded cycle-by-cycle and compared on the line.
module tb_uart_stim_tx;

    logic HCLK   = 1'b0;
    logic HRESET = 1'b1;
    logic mon_abort = 1'b0;
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_bad  = 0;
    int   done_a = 0;
    int   done_b = 0;
    logic [7:0] sb_a[$];
    logic [7:0] sb_b[$];
    int         starts_a[$];
    int         starts_b[$];

    uart_stim_tx_if #(.FIFO_DEPTH(8)) bus_a ();
    uart_stim_tx_if #(.FIFO_DEPTH(8)) bus_b ();

    uart_stim_tx #(.CLKS_PER_BIT(16), .FIFO_DEPTH(8)) dut_a (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus_a)
    );

    uart_stim_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(8)) dut_b (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus_b)
    );

    always #5 HCLK = ~HCLK;
    always @(posedge HCLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic tx_of(input int which);
        return (which == 0) ? bus_a.tx : bus_b.tx;
    endfunction

    // Follows one frame from its first low sample; every cycle is compared to the ideal waveform
    task automatic run_frame(input int which, input int cpb);
        logic [7:0] exp_b = 8'h00;
        logic [7:0] rx    = 8'h00;
        logic       have  = 1'b0;
        logic       lvl;
        logic       exp_lvl;
        int         errs  = 0;
        int         bi;
        if (which == 0) begin
            starts_a.push_back(cyc);
            have = (sb_a.size() != 0);
            if (have) exp_b = sb_a.pop_front();
        end else begin
            starts_b.push_back(cyc);
            have = (sb_b.size() != 0);
            if (have) exp_b = sb_b.pop_front();
        end
        chk("sb_has_entry", {31'd0, have}, 32'd1);
        for (int i = 0; i < 10 * cpb; i++) begin
            if (i > 0) @(negedge HCLK);
            if (which == 0 && mon_abort) return;
            lvl = tx_of(which);
            bi  = i / cpb;
            if (bi == 0)      exp_lvl = 1'b0;
            else if (bi == 9) exp_lvl = 1'b1;
            else              exp_lvl = exp_b[bi-1];
            if (lvl !== exp_lvl) errs++;
            if (bi >= 1 && bi <= 8 && (i % cpb) == cpb / 2) rx[bi-1] = lvl;
        end
        chk("frame_bits", errs, 0);
        chk("frame_byte", {24'd0, rx}, {24'd0, exp_b});
        if (which == 0) done_a++;
        else            done_b++;
    endtask

    initial begin : mon_a
        forever begin
            @(negedge HCLK);
            if (!HRESET && !mon_abort && tx_of(0) === 1'b0) run_frame(0, 16);
        end
    end

    initial begin : mon_b
        forever begin
            @(negedge HCLK);
            if (!HRESET && tx_of(1) === 1'b0) run_frame(1, 4);
        end
    end

    task automatic drive(input int which, input logic [7:0] d, input bit accept, output int edge_n);
        @(negedge HCLK);
        edge_n = cyc + 1;
        if (which == 0) begin
            bus_a.wr_en   = 1'b1;
            bus_a.wr_data = d;
            if (accept) sb_a.push_back(d);
        end else begin
            bus_b.wr_en   = 1'b1;
            bus_b.wr_data = d;
            if (accept) sb_b.push_back(d);
        end
    endtask

    task automatic release_wr();
        @(negedge HCLK);
        bus_a.wr_en = 1'b0;
        bus_b.wr_en = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int which, input int target, input int budget);
        int n = 0;
        while (((which == 0) ? done_a : done_b) < target && n < budget) begin
            @(negedge HCLK);
            n++;
        end
        chk(tag, (which == 0) ? done_a : done_b, target);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation did not finish");
    end

    initial begin : main
        int fe;
        int tmp;
        int st;
        int n;

        // Reset with pushes attempted: they must be ignored
        bus_a.wr_en = 1'b1; bus_a.wr_data = 8'hEE;
        bus_b.wr_en = 1'b1; bus_b.wr_data = 8'hEE;
        repeat (3) @(posedge HCLK);
        #1;
        chk("rst_tx",    bus_a.tx, 1);
        chk("rst_busy",  bus_a.busy, 0);
        chk("rst_full",  bus_a.full, 0);
        chk("rst_count", bus_a.count, 0);
        chk("rst_ovf",   bus_a.overflow, 0);
        chk("rst_tx_b",  bus_b.tx, 1);
        @(negedge HCLK);
        HRESET = 1'b0;
        bus_a.wr_en = 1'b0;
        bus_b.wr_en = 1'b0;
        @(negedge HCLK);
        chk("post_rst_count", bus_a.count, 0);

        // Minimum baud: 0xFF then 0x00 with no gap between frames
        drive(1, 8'hFF, 1'b1, fe);
        drive(1, 8'h00, 1'b1, tmp);
        release_wr();
        wait_done("frames_b", 1, 2, 200);
        chk("b_latency", starts_b[0] - fe, 2);
        chk("b_gap", starts_b[1] - starts_b[0], 40);

        // Single byte 0x55
        drive(0, 8'h55, 1'b1, fe);
        release_wr();
        chk("busy_55", bus_a.busy, 1);
        wait_done("frames_55", 0, 1, 400);
        chk("lat_55", starts_a[0] - fe, 2);
        repeat (2) @(negedge HCLK);
        chk("idle_busy_55", bus_a.busy, 0);
        chk("idle_tx_55", bus_a.tx, 1);

        // Back-to-back "ABC"
        drive(0, 8'h41, 1'b1, fe);
        drive(0, 8'h42, 1'b1, tmp);
        drive(0, 8'h43, 1'b1, tmp);
        release_wr();
        wait_done("frames_abc", 0, 4, 800);
        chk("lat_abc", starts_a[1] - fe, 2);
        chk("gap_ab", starts_a[2] - starts_a[1], 160);
        chk("gap_bc", starts_a[3] - starts_a[2], 160);

        // Overflow: ten pushes, the tenth is dropped
        for (int k = 0; k < 10; k++) drive(0, 8'(k), k < 9, tmp);
        release_wr();
        chk("ovf_full",  bus_a.full, 1);
        chk("ovf_flag",  bus_a.overflow, 1);
        chk("ovf_count", bus_a.count, 8);
        wait_done("frames_ovf", 0, 13, 9 * 160 + 200);
        chk("ovf_sticky",     bus_a.overflow, 1);
        chk("ovf_count_end",  bus_a.count, 0);
        chk("ovf_full_end",   bus_a.full, 0);

        // Reset during data bit 3 of 0xA5 with two bytes still queued
        drive(0, 8'hA5, 1'b1, tmp);
        drive(0, 8'h01, 1'b1, tmp);
        drive(0, 8'h02, 1'b1, tmp);
        release_wr();
        n = 0;
        while (starts_a.size() < 14 && n < 100) begin
            @(negedge HCLK);
            n++;
        end
        chk("rst_frame_started", starts_a.size(), 14);
        st = (starts_a.size() >= 14) ? starts_a[13] : cyc;
        while (cyc < st + 70) @(negedge HCLK);
        chk("queued_before_rst", bus_a.count, 2);
        mon_abort = 1'b1;
        HRESET    = 1'b1;
        @(posedge HCLK);
        #1;
        chk("abort_tx",    bus_a.tx, 1);
        chk("abort_count", bus_a.count, 0);
        chk("abort_busy",  bus_a.busy, 0);
        chk("abort_ovf",   bus_a.overflow, 0);
        @(negedge HCLK);
        HRESET = 1'b0;
        sb_a.delete();
        repeat (400) @(negedge HCLK);
        chk("no_more_frames", starts_a.size(), 14);
        chk("done_after_abort", done_a, 13);
        chk("tx_idle_after_abort", bus_a.tx, 1);
        mon_abort = 1'b0;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_stim_tx.md
UART_STIM_TX -- requirements
Module: uart_stim_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, SHALL set the HCLK cycles per serial bit (legal range 4..65535).
REQ-002 Parameter FIFO_DEPTH, default 8, SHALL set the transmit FIFO entries (power of 2, 2..64).
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 HCLK  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 HRESET  in  1  synchronous active-high reset.
REQ-006 wr_en  in  1  push strobe; wr_data is sampled on an HCLK edge where wr_en=1.
REQ-007 wr_data  in  8  byte to transmit.
REQ-008 full  out  1  FIFO holds FIFO_DEPTH entries.
REQ-009 count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-010 overflow  out  1  sticky flag: a push was dropped.
REQ-011 busy  out  1  high when FSM not IDLE or count!=0.
REQ-012 tx  out  1  serial line; drives the SoC UART RsRx input.

Function
REQ-013 Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1); each bit held exactly CLKS_PER_BIT cycles.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP; IDLE->START when count!=0 (pop same cycle); START->DATA after one bit time; DATA->STOP after 8th bit; STOP->START if count!=0 at end of stop bit, else IDLE.
REQ-015 Back-to-back frames SHALL have no idle gap: next start bit begins the cycle after the stop bit ends.
REQ-016 tx SHALL be a registered output, 1 in IDLE and STOP.
REQ-017 Latency: push on edge N into empty FIFO with FSM IDLE -> tx low from edge N+2.
REQ-018 full and count SHALL be registered; a push while full=1 SHALL be dropped even if a pop occurs that same cycle, and SHALL set overflow.
REQ-019 Simultaneous push and pop when not full SHALL leave count unchanged and preserve order.
REQ-020 Pop on empty SHALL never occur; FIFO pointers wrap modulo FIFO_DEPTH.
REQ-021 Bit counter and baud counter SHALL be internal; baud counter width $clog2(CLKS_PER_BIT).
REQ-022 overflow SHALL clear only on HRESET.

Reset
REQ-023 On HRESET=1 at an edge: tx=1, busy=0, full=0, count=0, overflow=0, FSM=IDLE, pointers=0.
REQ-024 Reset mid-frame SHALL abort the frame; tx=1 after that edge, queued bytes discarded.
REQ-025 wr_en during reset SHALL be ignored.

Structure
REQ-026 FSM state encoding and the 8N1 frame constants (data bits 8, start/stop levels) SHALL live in package uart_stim_pkg.
REQ-027 The FIFO SHALL be a separate sub-module uart_stim_fifo (sync, registered count/full, drop-on-full).
REQ-028 Implementation SHALL be synthesizable so the same block serves the simulation bench and the FPGA board.

Verification
REQ-029 Single byte: push 0x55, CLKS_PER_BIT=16 -> tx from edge N+2: 0,1,0,1,0,1,0,1,0,1 each 16 cycles, 160 cycles total, then busy=0.
REQ-030 Back-to-back: push 0x41,0x42,0x43 on consecutive cycles -> 480 contiguous cycles of frames, no gap; UART monitor at 160 ns/bit prints "ABC".
REQ-031 Overflow: push 0x00..0x09 on 10 consecutive cycles (DEPTH=8) -> 9 accepted, full=1 after 9th push, 0x09 dropped, overflow=1, 9 frames emitted in order.
REQ-032 Reset mid-frame: HRESET=1 during DATA bit 3 of 0xA5 with 2 bytes queued -> tx=1, count=0, busy=0 next edge; no further frames.
REQ-033 Boundary: CLKS_PER_BIT=4, push 0xFF and 0x00 -> each bit exactly 4 cycles; stop bit of 0xFF followed immediately by start bit of 0x00.
REQ-034 SoC loopback: connect tx to RsRx_Sys0_SS0_S0, firmware echoes to RsTx -> terminal prints the sent string.
